timer_cmd_receiver: RTL

TIMER_CMD_RECEIVER -- requirements
Module: timer_cmd_receiver

---
 rtl/timer_cmd_receiver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/timer_cmd_receiver.sv
// -----------------------------------------------------------------------------
// timer_cmd_receiver
//
// Purpose
//   Receives timer commands from a control-thread register and writes status
//   back to it. A command word carries a sequence number, an opcode and a
//   duration. A new command is recognised when its sequence number differs
//   from the last accepted one. The block runs a single countdown timer with
//   three states: IDLE, RUN and EXPIRED.
//
//   Command word (reg_q):  [W_D-1 -: W_SEQ] seq | [W_R +: 2] op | [W_R-1:0] dur
//   Status word  (reg_d):  [W_D-1 -: W_SEQ] last_seq | [W_R +: 2] state | [W_R-1:0] remaining
//   where W_R = W_D - W_SEQ - 2.
//   Opcodes:     0 NOP, 1 START, 2 STOP, 3 CLEAR
//   State codes: 0 IDLE, 1 RUN, 2 EXPIRED
//
// Timing
//   reg_q is registered once, and the command is decoded from that copy. An
//   accepted command therefore takes effect on the second rising edge after
//   reg_q changes. All outputs are registered.
//
// Handshake
//   There is no valid/ready pair on the command side. A command is "valid"
//   for exactly one cycle: the first cycle in which the registered seq field
//   differs from last_seq. reg_we is a one-cycle write strobe, and reg_d is
//   stable in between strobes. One strobe is issued per accepted command and
//   per expiry. When the two coincide, they share a single strobe.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   reg_q      command word read from the register
//   reg_d      status word written back
//   reg_we     status write strobe (one cycle)
//   busy       high while the timer is in RUN
//   expire     one-cycle pulse when the countdown reaches zero
//   remaining  current countdown value
//
// W_D must be at least 16 so that a useful duration field remains.
// -----------------------------------------------------------------------------
module timer_cmd_receiver #(
    parameter int W_D   = 32,
    parameter int W_SEQ = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [W_D-1:0]         reg_q,
    output logic [W_D-1:0]         reg_d,
    output logic                   reg_we,
    output logic                   busy,
    output logic                   expire,
    output logic [W_D-W_SEQ-3:0]   remaining
);

    localparam int W_R = W_D - W_SEQ - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_START = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [W_D-1:0]   cmd_word_q, cmd_word_d;   // registered copy of reg_q
    logic [W_SEQ-1:0] last_seq_q, last_seq_d;
    state_t           state_q,    state_d;
    logic [W_R-1:0]   rem_q,      rem_d;
    logic [W_D-1:0]   reg_d_q,    reg_d_d;
    logic             reg_we_q,   reg_we_d;
    logic             expire_q,   expire_d;
    logic             busy_q,     busy_d;

    // -------------------------------------------------------------------------
    // Command decode from the registered copy
    // -------------------------------------------------------------------------
    logic [W_SEQ-1:0] cmd_seq;
    op_t              cmd_op;
    logic [W_R-1:0]   cmd_dur;
    logic             cmd_valid;
    logic             count_en;

    always_comb begin
        cmd_seq   = cmd_word_q[W_D-1 -: W_SEQ];
        cmd_op    = op_t'(cmd_word_q[W_R +: 2]);
        cmd_dur   = cmd_word_q[W_R-1:0];
        // Only a change of seq is a new command. Equality covers both a held
        // word and an exact repeat. The all-ones to zero wrap is just another
        // change.
        cmd_valid = (cmd_seq != last_seq_q);
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_word_d = reg_q;
        last_seq_d = last_seq_q;
        state_d    = state_q;
        rem_d      = rem_q;
        reg_d_d    = reg_d_q;
        reg_we_d   = 1'b0;
        expire_d   = 1'b0;
        // The countdown runs in RUN unless START, STOP or CLEAR take over this
        // cycle. A NOP leaves it running, so an expiry on the same edge still
        // happens.
        count_en   = (state_q == ST_RUN);

        if (cmd_valid) begin
            last_seq_d = cmd_seq;
            reg_we_d   = 1'b1;
            unique case (cmd_op)
                OP_START: begin
                    count_en = 1'b0;
                    if (cmd_dur != '0) begin
                        rem_d   = cmd_dur;
                        state_d = ST_RUN;
                    end else begin
                        // A zero-length timer expires at once, and it is
                        // acknowledged in the same write.
                        rem_d    = '0;
                        state_d  = ST_EXPIRED;
                        expire_d = 1'b1;
                    end
                end
                OP_STOP: begin
                    count_en = 1'b0;
                    // Freeze the current count. Outside RUN this is a no-op.
                    if (state_q == ST_RUN) begin
                        state_d = ST_IDLE;
                    end
                end
                OP_CLEAR: begin
                    count_en = 1'b0;
                    state_d  = ST_IDLE;
                    rem_d    = '0;
                end
                default: begin
                    // NOP: ack only.
                end
            endcase
        end

        // Guarding on non-zero keeps the counter from wrapping even if RUN were
        // somehow entered with a zero count.
        if (count_en && (rem_q != '0)) begin
            rem_d = rem_q - W_R'(1);
            if (rem_q == W_R'(1)) begin
                state_d  = ST_EXPIRED;
                expire_d = 1'b1;
                reg_we_d = 1'b1;
            end
        end

        // The status word reflects the post-update values. It holds between
        // writes.
        if (reg_we_d) begin
            reg_d_d = {last_seq_d, state_d, rem_d};
        end

        busy_d = (state_d == ST_RUN);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_word_q <= '0;
            last_seq_q <= '0;
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            reg_d_q    <= '0;
            reg_we_q   <= 1'b0;
            expire_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_word_q <= cmd_word_d;
            last_seq_q <= last_seq_d;
            state_q    <= state_d;
            rem_q      <= rem_d;
            reg_d_q    <= reg_d_d;
            reg_we_q   <= reg_we_d;
            expire_q   <= expire_d;
            busy_q     <= busy_d;
        end
    end

    assign reg_d     = reg_d_q;
    assign reg_we    = reg_we_q;
    assign expire    = expire_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

endmodule
